// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder: FSM encodings,
// storage word type and the address decode helpers used by read and write sides.
package imem_pkg;

  localparam logic [31:0] BASE_ADDR_DEF = 32'h8000_0000;
  localparam int unsigned WORD_W        = 64;
  localparam int unsigned INST_W        = 32;
  localparam int unsigned STRB_W        = WORD_W / 8;

  typedef logic [WORD_W-1:0] imem_word_t;

  // Responder FSM encodings
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // True when addr falls inside [base, base + depth*8), evaluated without wrap
  function automatic logic in_range(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input int unsigned depth);
    logic [32:0] a;
    logic [32:0] lo;
    logic [32:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + (33'(depth) << 3);
    return (a >= lo) && (a < hi);
  endfunction

  // Fetch access fault: misaligned instruction or outside the array
  function automatic logic fetch_fault(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input int unsigned depth);
    return (addr[1:0] != 2'b00) || !in_range(addr, base, depth);
  endfunction

  // 64-bit word offset of a byte address relative to the array base
  function automatic logic [31:0] word_offset(input logic [31:0] addr,
                                              input logic [31:0] base);
    return (addr - base) >> 3;
  endfunction

endpackage

// File: rtl/imem_array.sv
// Program storage: DEPTH x 64-bit words, one combinational read port and one
// byte-strobed write port. A read on the same edge as a write to the same word
// observes the old contents because the write only lands at the clock edge.
module imem_array
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output imem_word_t        o_rd_data_c,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  imem_word_t        i_wr_data,
  input  logic [STRB_W-1:0] i_wr_strb
);

  imem_word_t r_mem [DEPTH];

  assign o_rd_data_c = r_mem[i_rd_idx];

  // Byte-lane write; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (i_wr_strb[b]) begin
          r_mem[i_wr_idx][8*b +: 8] <= i_wr_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Memory end of the fetch interface: accepts one fetch address at a time,
// waits LATENCY cycles, then presents the addressed 32-bit instruction
// (zero-extended to 64 bits) or an access fault until the consumer takes it.
module imem_responder
  import imem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned LATENCY   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  input  logic [31:0]       req_addr_i,
  output logic              req_ready_o,
  output logic              rsp_valid_o,
  output logic [WORD_W-1:0] rsp_data_o,
  output logic              rsp_err_o,
  input  logic              rsp_ready_i,
  input  logic              flush_i,
  input  logic              wr_en_i,
  input  logic [31:0]       wr_addr_i,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic [STRB_W-1:0] wr_strb_i
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [31:0]       r_addr;
  logic              w_ready;
  logic              w_accept;
  logic              w_sample;
  logic              w_rsp_done;

  logic              r_rsp_valid;
  imem_word_t        r_rsp_data;
  logic              r_rsp_err;

  logic [IDX_W-1:0]  w_rd_idx;
  imem_word_t        w_rd_word;
  logic              w_fault;
  imem_word_t        w_lane;

  logic              w_wr_en;
  logic [IDX_W-1:0]  w_wr_idx;

  // Read-side decode works off the latched address so req_* never reaches rsp_*
  assign w_rd_idx = IDX_W'(word_offset(r_addr, BASE_ADDR));
  assign w_fault  = fetch_fault(r_addr, BASE_ADDR, DEPTH);
  assign w_lane   = r_addr[2] ? {32'h0, w_rd_word[63:32]}
                              : {32'h0, w_rd_word[31:0]};

  // Writes bypass the FSM; anything outside the array is dropped
  assign w_wr_en  = wr_en_i & in_range(wr_addr_i, BASE_ADDR, DEPTH);
  assign w_wr_idx = IDX_W'(word_offset(wr_addr_i, BASE_ADDR));

  imem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk         (clk),
    .i_rd_idx    (w_rd_idx),
    .o_rd_data_c (w_rd_word),
    .i_wr_en     (w_wr_en),
    .i_wr_idx    (w_wr_idx),
    .i_wr_data   (wr_data_i),
    .i_wr_strb   (wr_strb_i)
  );

  // Next-state, counter and handshake decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ready     = 1'b0;
    w_accept    = 1'b0;
    w_sample    = 1'b0;
    w_rsp_done  = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = ~flush_i;
        if (req_valid_i && !flush_i) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (flush_i) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else if (r_cnt == '0) begin
          w_sample    = 1'b1;
          w_state_nxt = RESP;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      RESP: begin
        // A flush that coincides with rsp_ready_i is still a consumed response
        if (flush_i || rsp_ready_i) begin
          w_rsp_done  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and latency counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Capture the fetch address at acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
    end else if (w_accept) begin
      r_addr <= req_addr_i;
    end
  end

  // Response registers: loaded once on the sampling edge, held until consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_sample) begin
      r_rsp_valid <= 1'b1;
      r_rsp_err   <= w_fault;
      r_rsp_data  <= w_fault ? '0 : w_lane;
    end else if (w_rsp_done) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign req_ready_o = w_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_data_o  = r_rsp_data;
  assign rsp_err_o   = r_rsp_err;

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: three instances at LATENCY 1, 3 and 4
// share the write port; expected responses come from a bench-side memory model
// and are queued at request time, then checked when each response appears.
`timescale 1ns/1ps
module tb_imem_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int unsigned DEPTH = 64;
  localparam int          NDUT  = 3;
  localparam int          TMO   = 30;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid [NDUT];
  logic [31:0] req_addr  [NDUT];
  logic        req_ready [NDUT];
  logic        rsp_valid [NDUT];
  logic [63:0] rsp_data  [NDUT];
  logic        rsp_err   [NDUT];
  logic        rsp_ready [NDUT];
  logic        flush     [NDUT];
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_strb;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    int          d;
    logic [63:0] data;
    logic        err;
  } exp_t;

  exp_t        sb [$];
  logic [63:0] mem_m [DEPTH];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    imem_responder #(
      .BASE_ADDR (BASE),
      .DEPTH     (DEPTH),
      .LATENCY   ((g == 0) ? 1 : (g == 1) ? 3 : 4)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid_i (req_valid[g]),
      .req_addr_i  (req_addr[g]),
      .req_ready_o (req_ready[g]),
      .rsp_valid_o (rsp_valid[g]),
      .rsp_data_o  (rsp_data[g]),
      .rsp_err_o   (rsp_err[g]),
      .rsp_ready_i (rsp_ready[g]),
      .flush_i     (flush[g]),
      .wr_en_i     (wr_en),
      .wr_addr_i   (wr_addr),
      .wr_data_i   (wr_data),
      .wr_strb_i   (wr_strb)
    );
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 3 : 4;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [63:0] dat,
                                      input logic [7:0] s);
    longint la;
    longint lo;
    int     i;
    la = longint'(a);
    lo = longint'(BASE);
    if (la >= lo && la < lo + longint'(DEPTH) * 8) begin
      i = int'((la - lo) / 8);
      for (int b = 0; b < 8; b++)
        if (s[b]) mem_m[i][8*b +: 8] = dat[8*b +: 8];
    end
  endfunction

  function automatic void model_fetch(input logic [31:0] a, output logic [63:0] dat,
                                      output logic e);
    longint     la;
    longint     lo;
    logic [63:0] w;
    la = longint'(a);
    lo = longint'(BASE);
    e  = (a[1:0] != 2'b00) || la < lo || la >= lo + longint'(DEPTH) * 8;
    if (e) begin
      dat = 64'h0;
    end else begin
      w   = mem_m[int'((la - lo) / 8)];
      dat = a[2] ? {32'h0, w[63:32]} : {32'h0, w[31:0]};
    end
  endfunction

  // Drive the write port for the next edge and mirror it into the model
  task automatic drive_wr(input logic [31:0] a, input logic [63:0] dat, input logic [7:0] s);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = dat;
    wr_strb = s;
    model_write(a, dat, s);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [63:0] dat, input logic [7:0] s);
    @(negedge clk);
    drive_wr(a, dat, s);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Present a request and return just after the accepting edge
  task automatic issue(input int d, input logic [31:0] a, input bit push);
    exp_t e;
    int   n;
    if (push) begin
      e.d = d;
      model_fetch(a, e.data, e.err);
      sb.push_back(e);
    end
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_addr[d]  = a;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout dut%0d: req_ready_o=%b, required 1", d, req_ready[d]);
    end
    @(posedge clk);
  endtask

  // Wait for rsp_valid_o and check latency; optionally write the fetched word on the sampling edge
  task automatic wait_rsp(input int d, input bit coll, input logic [31:0] ca);
    int k;
    k = 0;
    @(negedge clk);
    req_valid[d] = 1'b0;
    while (1) begin
      wr_en = 1'b0;
      if (rsp_valid[d] === 1'b1 || k >= TMO) break;
      if (coll && k == lat_of(d) - 1) drive_wr(ca, 64'h5555_6666_7777_8888, 8'hFF);
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (rsp_valid[d] !== 1'b1 || k != lat_of(d)) begin
      n_err++;
      $display("FAIL latency dut%0d: got %0d cycles (valid=%b), required %0d",
               d, k, rsp_valid[d], lat_of(d));
    end
  endtask

  // Hold off the consumer for some cycles, then take the response and check it
  task automatic consume(input int d, input int hold, input bit post_wr, input logic [31:0] ca);
    exp_t e;
    e.d = d; e.data = 64'hx; e.err = 1'bx;
    if (sb.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL scoreboard dut%0d: response with no expected entry", d);
    end else begin
      e = sb.pop_front();
    end
    for (int i = 0; i < hold; i++) begin
      wr_en = 1'b0;
      if (post_wr && i == 0) drive_wr(ca, 64'h9999_AAAA_BBBB_CCCC, 8'hFF);
      @(negedge clk);
      n_vec++;
      if (rsp_valid[d] !== 1'b1 || rsp_data[d] !== e.data || req_ready[d] !== 1'b0) begin
        n_err++;
        $display("FAIL hold dut%0d cyc%0d: valid=%b data=%h ready=%b, required 1 %h 0",
                 d, i, rsp_valid[d], rsp_data[d], req_ready[d], e.data);
      end
    end
    wr_en = 1'b0;
    n_vec++;
    if (rsp_data[d] !== e.data || rsp_err[d] !== e.err) begin
      n_err++;
      $display("FAIL rsp dut%0d: data=%h err=%b, required %h %b",
               d, rsp_data[d], rsp_err[d], e.data, e.err);
    end
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    n_vec++;
    if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
      n_err++;
      $display("FAIL consume dut%0d: valid=%b ready=%b, required 0 1",
               d, rsp_valid[d], req_ready[d]);
    end
  endtask

  task automatic fetch(input int d, input logic [31:0] a, input int hold);
    issue(d, a, 1'b1);
    wait_rsp(d, 1'b0, 32'h0);
    consume(d, hold, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      n_vec++;
      if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0 || rsp_data[d] !== 64'h0 ||
          rsp_err[d] !== 1'b0) begin
        n_err++;
        $display("FAIL reset dut%0d: ready=%b valid=%b data=%h err=%b, required 1 0 0 0",
                 d, req_ready[d], rsp_valid[d], rsp_data[d], rsp_err[d]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    flush[0] = 1'b1;
    #1;
    n_vec++;
    if (req_ready[0] !== 1'b0) begin
      n_err++;
      $display("FAIL flush_ready: req_ready_o=%b with flush in IDLE, required 0", req_ready[0]);
    end
    flush[0] = 1'b0;
  endtask

  task automatic test_basic_fetch();
    do_write(BASE, 64'h0010_0093_0000_0413, 8'hFF);
    fetch(0, BASE, 0);
    fetch(0, BASE + 32'h4, 0);
  endtask

  task automatic test_latency_hold();
    fetch(1, BASE + 32'h4, 4);
    fetch(2, BASE, 2);
  endtask

  task automatic test_errors();
    do_write(BASE + 32'(DEPTH * 8) - 32'h8, 64'h0000_0067_0000_8067, 8'hFF);
    fetch(0, 32'h7FFF_FFFC, 0);
    fetch(0, BASE + 32'(DEPTH * 8), 0);
    fetch(0, BASE + 32'h2, 0);
    fetch(0, 32'hFFFF_FFFC, 0);
    fetch(0, BASE + 32'(DEPTH * 8) - 32'h4, 0);
    fetch(1, BASE + 32'h1, 1);
  endtask

  task automatic test_strobe();
    do_write(BASE + 32'h8, 64'h1111_1111_2222_2222, 8'hFF);
    do_write(BASE + 32'h8, 64'hFFFF_FFFF_DEAD_BEEF, 8'h0F);
    fetch(0, BASE + 32'hC, 0);
    fetch(0, BASE + 32'h8, 0);
    do_write(BASE + 32'(DEPTH * 8), 64'hBAD0_BAD0_BAD0_BAD0, 8'hFF);
    do_write(32'h7FFF_FFF8, 64'hBAD1_BAD1_BAD1_BAD1, 8'hFF);
    fetch(0, BASE, 0);
    do_write(BASE + 32'h15, 64'h0000_0000_CAFE_F00D, 8'h30);
    fetch(1, BASE + 32'h10, 0);
  endtask

  task automatic test_collision();
    do_write(BASE + 32'h18, 64'hAAAA_0001_BBBB_0002, 8'hFF);
    issue(0, BASE + 32'h18, 1'b1);
    wait_rsp(0, 1'b1, BASE + 32'h1B);
    consume(0, 2, 1'b1, BASE + 32'h18);
    fetch(0, BASE + 32'h18, 0);
    do_write(BASE + 32'h20, 64'h1234_5678_9ABC_DEF0, 8'hFF);
    issue(1, BASE + 32'h24, 1'b1);
    wait_rsp(1, 1'b1, BASE + 32'h20);
    consume(1, 3, 1'b1, BASE + 32'h20);
    fetch(1, BASE + 32'h24, 0);
  endtask

  task automatic test_flush();
    do_write(BASE + 32'h28, 64'h0000_0013_0000_0073, 8'hFF);
    issue(2, BASE + 32'h28, 1'b0);
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(negedge clk);
    flush[2] = 1'b1;
    @(negedge clk);
    flush[2] = 1'b0;
    #1;
    n_vec++;
    if (req_ready[2] !== 1'b1) begin
      n_err++;
      $display("FAIL flush_wait_ready: req_ready_o=%b, required 1", req_ready[2]);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_vec++;
      if (rsp_valid[2] !== 1'b0) begin
        n_err++;
        $display("FAIL flush_wait_valid cyc%0d: rsp_valid_o=%b, required 0", i, rsp_valid[2]);
      end
    end
    fetch(2, BASE + 32'h28, 0);
    issue(0, BASE, 1'b0);
    wait_rsp(0, 1'b0, 32'h0);
    flush[0] = 1'b1;
    @(negedge clk);
    flush[0] = 1'b0;
    #1;
    n_vec++;
    if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
      n_err++;
      $display("FAIL flush_resp: valid=%b ready=%b, required 0 1", rsp_valid[0], req_ready[0]);
    end
    fetch(0, BASE + 32'h2C, 0);
  endtask

  // Stream requests with rsp_ready_i held high and check the acceptance spacing
  task automatic test_back_to_back(input int d);
    logic [31:0] addrs [3];
    exp_t        e;
    int          idx;
    int          nresp;
    int          last_acc;
    bit          acc_prev;
    addrs[0] = BASE + 32'h4;
    addrs[1] = BASE + 32'hC;
    addrs[2] = BASE + 32'h28;
    idx = 0; nresp = 0; last_acc = -1; acc_prev = 1'b0;
    @(negedge clk);
    rsp_ready[d] = 1'b1;
    req_valid[d] = 1'b1;
    req_addr[d]  = addrs[0];
    for (int n = 0; n < 60 && nresp < 3; n++) begin
      if (n > 0) @(negedge clk);
      if (acc_prev) begin
        acc_prev = 1'b0;
        if (idx < 3) req_addr[d] = addrs[idx];
        else         req_valid[d] = 1'b0;
      end
      if (rsp_valid[d] === 1'b1) begin
        nresp++;
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL b2b_sb dut%0d: response with no expected entry", d);
        end else begin
          e = sb.pop_front();
          if (rsp_data[d] !== e.data || rsp_err[d] !== e.err) begin
            n_err++;
            $display("FAIL b2b_rsp dut%0d: data=%h err=%b, required %h %b",
                     d, rsp_data[d], rsp_err[d], e.data, e.err);
          end
        end
      end
      if (req_valid[d] === 1'b1 && req_ready[d] === 1'b1) begin
        e.d = d;
        model_fetch(req_addr[d], e.data, e.err);
        sb.push_back(e);
        if (last_acc >= 0) begin
          n_vec++;
          if (cyc - last_acc != lat_of(d) + 2) begin
            n_err++;
            $display("FAIL b2b_rate dut%0d: %0d cycles between accepts, required %0d",
                     d, cyc - last_acc, lat_of(d) + 2);
          end
        end
        last_acc = cyc;
        idx++;
        acc_prev = 1'b1;
      end
    end
    if (nresp < 3) begin
      n_vec++; n_err++;
      $display("FAIL b2b_timeout dut%0d: %0d responses, required 3", d, nresp);
    end
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    req_valid[d] = 1'b0;
  endtask

  task automatic test_reset_mid();
    issue(1, BASE, 1'b0);
    wait_rsp(1, 1'b0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if (rsp_valid[1] !== 1'b0 || rsp_data[1] !== 64'h0 || req_ready[1] !== 1'b1) begin
      n_err++;
      $display("FAIL reset_resp: valid=%b data=%h ready=%b, required 0 0 1",
               rsp_valid[1], rsp_data[1], req_ready[1]);
    end
    issue(2, BASE, 1'b0);
    @(negedge clk);
    req_valid[2] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (rsp_valid[2] !== 1'b0 || req_ready[2] !== 1'b1) begin
        n_err++;
        $display("FAIL reset_wait cyc%0d: valid=%b ready=%b, required 0 1",
                 i, rsp_valid[2], req_ready[2]);
      end
      @(negedge clk);
    end
    fetch(2, BASE + 32'h4, 0);
  endtask

  initial begin
    rst = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    for (int d = 0; d < NDUT; d++) begin
      req_valid[d] = 1'b0; req_addr[d] = '0; rsp_ready[d] = 1'b0; flush[d] = 1'b0;
    end
    test_reset();
    test_basic_fetch();
    test_latency_hold();
    test_errors();
    test_strobe();
    test_collision();
    test_flush();
    test_back_to_back(0);
    test_back_to_back(1);
    test_reset_mid();
    if (sb.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL sb_leftover: %0d expected responses never seen, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder serving the fetch side of the core: accepts one 32-bit fetch address per handshake, waits a configurable number of cycles, and returns a 64-bit word with the addressed instruction in bits [31:0]. It is the memory end of the pc_valid/pc_ready ↔ inst64 fetch interface. It holds program storage as an internal 64-bit-wide array. A byte-strobed write port loads and patches that storage.

## Interface
- BASE_ADDR, 32'h8000_0000, byte address of array word 0
- DEPTH, 4096, number of 64-bit words (power of two, ≥2)
- LATENCY, 1, cycles from request acceptance to rsp_valid_o (≥1)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid_i  in  1  fetch request valid (driven from the fetch unit's pc valid)
- req_addr_i  in  32  fetch byte address
- req_ready_o  out  1  request accepted when req_valid_i & req_ready_o
- rsp_valid_o  out  1  response valid
- rsp_data_o  out  64  addressed instruction in [31:0], upper 32 bits zero
- rsp_err_o  out  1  access fault (out of range or misaligned)
- rsp_ready_i  in  1  consumer accepts response
- flush_i  in  1  discard any outstanding request or response
- wr_en_i  in  1  storage write
- wr_addr_i  in  32  write byte address; bits [2:0] ignored
- wr_data_i  in  64  write data
- wr_strb_i  in  8  byte enables, bit i covers wr_data_i[8i+7:8i]

## Operation
- FSM states: IDLE, WAIT, RESP. Reset → IDLE.
- IDLE: req_ready_o = ~flush_i. On acceptance, latch req_addr_i, load the counter with LATENCY-1, and go to WAIT.
- WAIT: decrement the counter. When the counter is 0, sample the array and go to RESP.
- RESP: rsp_valid_o=1. Data and error are held stable until rsp_ready_i=1, then go to IDLE.
- Only one request is outstanding at a time. req_ready_o=0 in WAIT and RESP.
- Index = (addr - BASE_ADDR) >> 3. rsp_data_o = addr[2] ? {32'h0, word[63:32]} : {32'h0, word[31:0]}.
- Error if addr[1:0] ≠ 0, or addr < BASE_ADDR, or addr ≥ BASE_ADDR + DEPTH*8 (compare in 33-bit arithmetic, no wrap). On error: rsp_data_o=0, rsp_err_o=1, and the response still completes the handshake.
- flush_i in WAIT or RESP: go to IDLE next cycle with no response. rsp_valid_o drops the following cycle. A flush coinciding with rsp_ready_i still counts as consumed.
- Writes are independent of the FSM. Out-of-range writes are dropped silently.
- Read/write collision on the sampling cycle: the read returns the pre-write contents.
- Writes after sampling do not alter a held response.

## Timing
- Reset values: req_ready_o=1 (subject to flush_i), rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0; counter=0, latched address=0.
- Array contents are not reset.
- Acceptance at edge t → rsp_valid_o high from edge t+LATENCY.
- Back-to-back rate: one response per LATENCY+2 cycles with rsp_ready_i held 1. This covers accept, LATENCY cycles, consume, and return to IDLE.
- rst asserted mid-WAIT or mid-RESP: IDLE next edge, outstanding response lost.
- rsp_data_o and rsp_err_o are registered. No combinational path from req_* to rsp_*.
- req_ready_o depends combinationally only on state and flush_i.

## Structure
- Shared package imem_pkg: state enum (IDLE/WAIT/RESP), BASE_ADDR default, 64-bit word type, address-range check function.
- One sub-module: imem_array, a DEPTH×64 single-read/single-write array with byte strobes and read-before-write ordering.
- imem_responder contains the FSM, latency counter, address decode and response registers.

## Test plan
- Load 0x8000_0000 with 64'h00100093_00000413. Fetch 0x8000_0000 → rsp_data_o=64'h0000_0000_0000_0413 after 1 cycle. Fetch 0x8000_0004 → 64'h0000_0000_0010_0093.
- LATENCY=3, request accepted at cycle 10 → rsp_valid_o rises at cycle 13. Hold rsp_ready_i=0 for 4 cycles → data stable and req_ready_o=0 throughout.
- Fetch 0x7fff_fffc → rsp_err_o=1, data 0. Fetch BASE_ADDR+DEPTH*8 → err=1. Fetch 0x8000_0002 → err=1.
- LATENCY=4, flush_i 2 cycles after acceptance → no rsp_valid_o ever. req_ready_o=1 the cycle after flush deasserts. The next fetch returns correct data.
- Write strobe 8'h0F, data 64'hFFFF_FFFF_DEAD_BEEF at 0x8000_0008 over existing 64'h1111_1111_2222_2222 → fetch 0x8000_000C returns 0x1111_1111, fetch 0x8000_0008 returns 0xDEAD_BEEF.
- Write to the sampled word on the sampling cycle → old value returned. Assert rst during RESP → rsp_valid_o=0 next cycle.
